// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI bus arbiter codebase slice.
//   - arb_state_e : arbiter FSM states (IDLE, GRANT, BUSY)
//   - DEV_ADDR_*  : device address constants already in use on the bus
//   - CBE_*       : C/BE command encodings used by bus agents
package pci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    localparam logic [7:0] DEV_ADDR_A = 8'hAD;
    localparam logic [7:0] DEV_ADDR_B = 8'hBD;
    localparam logic [7:0] DEV_ADDR_C = 8'hCD;

    localparam logic [3:0] CBE_WRITE = 4'b0100;
    localparam logic [3:0] CBE_READ  = 4'b0001;

endpackage

// File: rtl/pci_rr_pick.sv
// pci_rr_pick: combinational round-robin selector.
// Ports:
//   req_i    [N_DEV]  active-high request vector
//   ptr_i    [log2]   index of the last owner (lowest priority)
//   winner_o [log2]   first requester scanning ptr+1, ptr+2, ... mod N_DEV
//   any_o             high when at least one request is present
module pci_rr_pick #(
    parameter int N_DEV = 3
) (
    input  logic [N_DEV-1:0]         req_i,
    input  logic [$clog2(N_DEV)-1:0] ptr_i,
    output logic [$clog2(N_DEV)-1:0] winner_o,
    output logic                     any_o
);
    localparam int PW = $clog2(N_DEV);

    int            idx;
    logic [PW-1:0] idx_w;

    // Scan from the farthest position back to the nearest; the last hit
    // written is the nearest requester after ptr, which is the winner.
    always_comb begin
        winner_o = '0;
        any_o    = |req_i;
        idx      = 0;
        idx_w    = '0;
        for (int i = N_DEV; i >= 1; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= N_DEV) begin
                idx = idx - N_DEV;
            end
            idx_w = PW'(idx);
            if (req_i[idx_w]) begin
                winner_o = idx_w;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: central round-robin arbiter for a shared PCI bus.
// Ports:
//   clk, rst      bus clock, synchronous active-high reset
//   REQ  [N_DEV]  active-low requests from the devices
//   FRAME, IRDY   active-low bus activity, sensed only
//   GNT  [N_DEV]  active-low registered grants, at most one low
//   owner         index of the current or last bus owner
//   owner_vld     high while the owner's transaction is in progress
//   dbg_state_o   current FSM state, for observation only
// Build option: define PCI_ARB_PARK_EN to park the bus on the last owner
// while nobody is requesting.
//
// Handshake: a device requests by holding REQ low; it may start a
// transaction only while its GNT is low and the bus is idle. Dropping REQ
// before FRAME is seen withdraws the request; an unused grant is revoked
// after GNT_TIMEOUT cycles. Once FRAME is seen the transaction runs to the
// next idle-bus sample, even if GNT is taken away for a waiting device.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int N_DEV       = 3,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DEV-1:0]         REQ,
    input  logic                     FRAME,
    input  logic                     IRDY,
    output logic [N_DEV-1:0]         GNT,
    output logic [$clog2(N_DEV)-1:0] owner,
    output logic                     owner_vld,
    output arb_state_e               dbg_state_o
);
    localparam int               PW        = $clog2(N_DEV);
    localparam logic [N_DEV-1:0] ONE       = {{(N_DEV-1){1'b0}}, 1'b1};
    localparam logic [7:0]       TCNT_LAST = 8'(GNT_TIMEOUT - 1);

    arb_state_e       state_q;
    logic [N_DEV-1:0] gnt_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    w_q;
    logic [PW-1:0]    owner_q;
    logic [7:0]       tcnt_q;
    logic [7:0]       tcnt_d;
    logic             owner_vld_q;

    logic [N_DEV-1:0] req_act;
    logic             bus_idle;
    logic [PW-1:0]    pick_w;
    logic             pick_any;
    logic [N_DEV-1:0] pick_gnt;
    logic [N_DEV-1:0] w_mask;
    logic             others_req;
    logic             w_req;

    assign req_act    = ~REQ;
    assign bus_idle   = FRAME & IRDY;
    assign pick_gnt   = ~(ONE << pick_w);
    assign w_mask     = ONE << w_q;
    assign others_req = |(req_act & ~w_mask);
    assign w_req      = req_act[w_q];
    assign tcnt_d     = tcnt_q + 8'd1;

    pci_rr_pick #(
        .N_DEV (N_DEV)
    ) u_pick (
        .req_i    (req_act),
        .ptr_i    (ptr_q),
        .winner_o (pick_w),
        .any_o    (pick_any)
    );

`ifdef PCI_ARB_PARK_EN
    logic             parked_q;
    logic [N_DEV-1:0] park_gnt;
    assign park_gnt = ~(ONE << owner_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '1;
            ptr_q       <= PW'(N_DEV - 1);
            w_q         <= '0;
            owner_q     <= '0;
            tcnt_q      <= '0;
            owner_vld_q <= 1'b0;
`ifdef PCI_ARB_PARK_EN
            parked_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                    if (parked_q && !FRAME) begin
                        // Parked owner started a transaction: GNT stays low.
                        state_q     <= ST_BUSY;
                        w_q         <= owner_q;
                        owner_vld_q <= 1'b1;
                        parked_q    <= 1'b0;
                    end else if (parked_q && pick_any) begin
                        // Release the parked grant for one all-high cycle
                        // so grants to different devices never overlap.
                        gnt_q    <= '1;
                        parked_q <= 1'b0;
                    end else if (!pick_any) begin
                        gnt_q    <= park_gnt;
                        parked_q <= 1'b1;
                    end else if (bus_idle) begin
                        state_q <= ST_GRANT;
                        w_q     <= pick_w;
                        gnt_q   <= pick_gnt;
                        tcnt_q  <= '0;
                    end else begin
                        gnt_q <= '1;
                    end
`else
                    if (pick_any && bus_idle) begin
                        state_q <= ST_GRANT;
                        w_q     <= pick_w;
                        gnt_q   <= pick_gnt;
                        tcnt_q  <= '0;
                    end else begin
                        gnt_q <= '1;
                    end
`endif
                end
                ST_GRANT: begin
                    tcnt_q <= tcnt_d;
                    // FRAME takes priority over a withdrawn request or timeout.
                    if (!FRAME) begin
                        state_q     <= ST_BUSY;
                        owner_q     <= w_q;
                        owner_vld_q <= 1'b1;
                    end else if (!w_req) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '1;
                    end else if (tcnt_q == TCNT_LAST) begin
                        // Timed-out device drops to lowest priority.
                        state_q <= ST_IDLE;
                        gnt_q   <= '1;
                        ptr_q   <= w_q;
                    end
                end
                ST_BUSY: begin
                    if (bus_idle) begin
                        state_q     <= ST_IDLE;
                        ptr_q       <= w_q;
                        owner_vld_q <= 1'b0;
                        gnt_q       <= '1;
                    end else if (others_req) begin
                        // Early release lets the next owner be picked as
                        // soon as the bus goes idle; never re-asserted here.
                        gnt_q <= '1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '1;
                end
            endcase
        end
    end

    assign GNT         = gnt_q;
    assign owner       = owner_q;
    assign owner_vld   = owner_vld_q;
    assign dbg_state_o = state_q;

endmodule
